// File: rtl/sonic_v1_15_sysid_checker.sv
// Boot-time system-ID checker: reads sysid words 0 and 1 over an Avalon-MM
// read master, compares them with build constants and reports the result.
module sonic_v1_15_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h38D8_FF5B,
    parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
    parameter bit          CHECK_TS       = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        id_ok_o,
    output logic        ts_ok_o,
    output logic        error_o,
    output logic [31:0] id_value_o,
    output logic [31:0] ts_value_o,
    output logic [3:0]  retry_count_o,
    output logic        avm_address_o,
    output logic        avm_read_o,
    input  logic        avm_waitrequest_i,
    input  logic [31:0] avm_readdata_i
);

    // state    | meaning
    // S_IDLE   | waiting for start
    // S_RD_ID  | reading word 0 (system ID)
    // S_RD_TS  | reading word 1 (timestamp)
    // S_GAP    | read dropped for one cycle before a retry
    // S_CHECK  | comparing captured words
    // S_DONE   | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_RD_TS,
        S_GAP,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RTRY_MAX = 4'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic [15:0] tmo_q, tmo_d;
    logic [3:0]  rtry_q, rtry_d;
    logic        gap_ts_q, gap_ts_d;
    logic [3:0]  retry_cnt_q, retry_cnt_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        error_q, error_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;
    logic        busy_q, done_q, read_q, addr_q;

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        rtry_d      = rtry_q;
        gap_ts_d    = gap_ts_q;
        retry_cnt_d = retry_cnt_q;
        id_ok_d     = id_ok_q;
        ts_ok_d     = ts_ok_q;
        error_d     = error_q;
        id_value_d  = id_value_q;
        ts_value_d  = ts_value_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    id_ok_d     = 1'b0;
                    ts_ok_d     = 1'b0;
                    error_d     = 1'b0;
                    retry_cnt_d = 4'd0;
                    tmo_d       = 16'd0;
                    rtry_d      = 4'd0;
                    state_d     = S_RD_ID;
                end
            end
            S_RD_ID, S_RD_TS: begin
                if (!avm_waitrequest_i) begin
                    tmo_d  = 16'd0;
                    rtry_d = 4'd0;
                    if (state_q == S_RD_ID) begin
                        id_value_d = avm_readdata_i;
                        state_d    = S_RD_TS;
                    end else begin
                        ts_value_d = avm_readdata_i;
                        state_d    = S_CHECK;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d = 16'd0;
                    if (rtry_q < RTRY_MAX) begin
                        rtry_d   = rtry_q + 4'd1;
                        gap_ts_d = (state_q == S_RD_TS);
                        state_d  = S_GAP;
                        if (retry_cnt_q != 4'hF) begin
                            retry_cnt_d = retry_cnt_q + 4'd1;
                        end
                    end else begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_GAP: begin
                state_d = gap_ts_q ? S_RD_TS : S_RD_ID;
            end
            S_CHECK: begin
                id_ok_d = (id_value_q == EXPECTED_ID);
                ts_ok_d = CHECK_TS ? (ts_value_q == EXPECTED_TS) : 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus and handshake outputs are registered from the next state so they
    // line up with the state they belong to without any input-to-output path.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            tmo_q       <= 16'd0;
            rtry_q      <= 4'd0;
            gap_ts_q    <= 1'b0;
            retry_cnt_q <= 4'd0;
            id_ok_q     <= 1'b0;
            ts_ok_q     <= 1'b0;
            error_q     <= 1'b0;
            id_value_q  <= 32'd0;
            ts_value_q  <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            read_q      <= 1'b0;
            addr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            rtry_q      <= rtry_d;
            gap_ts_q    <= gap_ts_d;
            retry_cnt_q <= retry_cnt_d;
            id_ok_q     <= id_ok_d;
            ts_ok_q     <= ts_ok_d;
            error_q     <= error_d;
            id_value_q  <= id_value_d;
            ts_value_q  <= ts_value_d;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            read_q      <= (state_d == S_RD_ID) || (state_d == S_RD_TS);
            addr_q      <= (state_d == S_RD_TS);
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign id_ok_o       = id_ok_q;
    assign ts_ok_o       = ts_ok_q;
    assign error_o       = error_q;
    assign id_value_o    = id_value_q;
    assign ts_value_o    = ts_value_q;
    assign retry_count_o = retry_cnt_q;
    assign avm_address_o = addr_q;
    assign avm_read_o    = read_q;

endmodule

// File: tb/tb_sonic_v1_15_sysid_checker.sv
// Bench for the sysid checker: a default-configured instance (A) and a
// timestamp-checking, short-timeout instance (B) share one stalling slave.
module tb_sonic_v1_15_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'h38D8_FF5B;
    localparam logic [31:0] EXP_TS_B = 32'h4C8A_1F00;
    localparam int TMO_B = 4;
    localparam int RTR_B = 2;

    logic clk, rst_n, start, wr;
    logic [31:0] id_word, ts_word, rd_a, rd_b;
    int stall_target, stall_cnt;
    bit stuck;

    logic busy_a, done_a, id_ok_a, ts_ok_a, err_a, addr_a, read_a;
    logic [31:0] idv_a, tsv_a;
    logic [3:0] rc_a;
    logic busy_b, done_b, id_ok_b, ts_ok_b, err_b, addr_b, read_b;
    logic [31:0] idv_b, tsv_b;
    logic [3:0] rc_b;

    int tests = 0;
    int fails = 0;

    sonic_v1_15_sysid_checker dut_a (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(start),
        .busy_o(busy_a), .done_o(done_a), .id_ok_o(id_ok_a), .ts_ok_o(ts_ok_a),
        .error_o(err_a), .id_value_o(idv_a), .ts_value_o(tsv_a),
        .retry_count_o(rc_a), .avm_address_o(addr_a), .avm_read_o(read_a),
        .avm_waitrequest_i(wr), .avm_readdata_i(rd_a));

    sonic_v1_15_sysid_checker #(
        .EXPECTED_TS(EXP_TS_B), .CHECK_TS(1'b1),
        .TIMEOUT_CYCLES(TMO_B), .MAX_RETRIES(RTR_B)
    ) dut_b (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(start),
        .busy_o(busy_b), .done_o(done_b), .id_ok_o(id_ok_b), .ts_ok_o(ts_ok_b),
        .error_o(err_b), .id_value_o(idv_b), .ts_value_o(tsv_b),
        .retry_count_o(rc_b), .avm_address_o(addr_b), .avm_read_o(read_b),
        .avm_waitrequest_i(wr), .avm_readdata_i(rd_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: stalls each read for stall_target cycles, or forever when stuck.
    assign rd_a = addr_a ? ts_word : id_word;
    assign rd_b = addr_b ? ts_word : id_word;
    assign wr   = stuck || (read_b && (stall_cnt < stall_target));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt <= 0;
        else if (read_b && wr) stall_cnt <= stall_cnt + 1;
        else stall_cnt <= 0;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy_a, done_a, id_ok_a, ts_ok_a, err_a, read_a, addr_a, idv_a, tsv_a, rc_a} !== '0 ||
            {busy_b, done_b, id_ok_b, ts_ok_b, err_b, read_b, addr_b, idv_b, tsv_b, rc_b} !== '0) begin
            fails++;
            $display("FAIL reset_values: a=%0b%0b%0b%0b%0b%0b%0b %h %h %h b=%0b%0b%0b%0b%0b%0b%0b %h %h %h required all zero",
                     busy_a, done_a, id_ok_a, ts_ok_a, err_a, read_a, addr_a, idv_a, tsv_a, rc_a,
                     busy_b, done_b, id_ok_b, ts_ok_b, err_b, read_b, addr_b, idv_b, tsv_b, rc_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_sequence();
        id_word = EXP_ID;
        ts_word = 32'hDEAD_BEEF;
        stall_target = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if (!(read_b && addr_b && wr && idv_b == EXP_ID)) begin
            fails++;
            $display("FAIL mid_setup: read=%0b addr=%0b wr=%0b idv=%h required 1 1 1 %h",
                     read_b, addr_b, wr, idv_b, EXP_ID);
        end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({busy_a, done_a, read_a, addr_a, idv_a, tsv_a} !== '0 ||
            {busy_b, done_b, read_b, addr_b, idv_b, tsv_b} !== '0) begin
            fails++;
            $display("FAIL async_reset: a busy=%0b read=%0b idv=%h b busy=%0b read=%0b idv=%h required zeros",
                     busy_a, read_a, idv_a, busy_b, read_b, idv_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            tests++;
            if (done_a !== 1'b0 || done_b !== 1'b0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
                fails++;
                $display("FAIL no_done_after_reset k=%0d: done=%0b/%0b busy=%0b/%0b required 0",
                         k, done_a, done_b, busy_a, busy_b);
            end
        end
    endtask

    task automatic test_timeout_retry();
        int done_k;
        bit exp_read;
        done_k = (RTR_B + 1) * TMO_B + RTR_B + 1;
        id_word = EXP_ID;
        ts_word = 32'h0;
        stuck = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= done_k; k++) begin
            if (k > 1) @(negedge clk);
            exp_read = (k < done_k) && (((k - 1) % (TMO_B + 1)) < TMO_B);
            tests++;
            if ({busy_b, done_b, read_b, addr_b} !== {1'b1, k == done_k, exp_read, 1'b0}) begin
                fails++;
                $display("FAIL timeout_ctl k=%0d: busy/done/read/addr=%0b%0b%0b%0b required 1%0b%0b0",
                         k, busy_b, done_b, read_b, addr_b, k == done_k, exp_read);
            end
        end
        tests++;
        if (err_b !== 1'b1 || rc_b !== 4'(RTR_B) || id_ok_b !== 1'b0 || ts_ok_b !== 1'b0) begin
            fails++;
            $display("FAIL timeout_result: err=%0b retries=%0d id_ok=%0b ts_ok=%0b required 1 %0d 0 0",
                     err_b, rc_b, id_ok_b, ts_ok_b, RTR_B);
        end
        tests++;
        if (read_a !== 1'b1 || busy_a !== 1'b1 || err_a !== 1'b0 || rc_a !== 4'd0) begin
            fails++;
            $display("FAIL long_timeout_still_reading: read=%0b busy=%0b err=%0b rc=%0d required 1 1 0 0",
                     read_a, busy_a, err_a, rc_a);
        end
        rst_n = 1'b0;
        stuck = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests++;
        if (err_b !== 1'b0 || rc_b !== 4'd0 || read_a !== 1'b0) begin
            fails++;
            $display("FAIL reset_clears_error: err=%0b rc=%0d read_a=%0b required 0 0 0", err_b, rc_b, read_a);
        end
        @(negedge clk);
    endtask

    task automatic test_main_sequence();
        logic [31:0] t_id[4] = '{EXP_ID, 32'h1234_5678, EXP_ID, EXP_ID};
        logic [31:0] t_ts[4] = '{32'h0, 32'h0, 32'h4C8A_1F01, EXP_TS_B};
        int          t_st[4] = '{0, 0, 0, 3};
        logic [31:0] idw, tsw;
        int s, lat;
        bit e_rd, e_ad, e_idok, e_tsb;
        for (int c = 0; c < 24; c++) begin
            if (c < 4) begin
                idw = t_id[c];
                tsw = t_ts[c];
                s = t_st[c];
            end else begin
                idw = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom();
                case ($urandom_range(0, 2))
                    0: tsw = EXP_TS_B;
                    1: tsw = 32'h0;
                    default: tsw = $urandom();
                endcase
                s = $urandom_range(0, TMO_B - 1);
            end
            id_word = idw;
            ts_word = tsw;
            stall_target = s;
            lat = 4 + 2 * s;
            e_idok = (idw == EXP_ID);
            e_tsb = (tsw == EXP_TS_B);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int k = 1; k <= lat; k++) begin
                if (k > 1) @(negedge clk);
                e_rd = (k <= 2 * s + 2);
                e_ad = e_rd && (k > s + 1);
                tests++;
                if ({busy_a, done_a, read_a, addr_a} !== {1'b1, k == lat, e_rd, e_ad} ||
                    {busy_b, done_b, read_b, addr_b} !== {1'b1, k == lat, e_rd, e_ad}) begin
                    fails++;
                    $display("FAIL seq_ctl c=%0d k=%0d: a=%0b%0b%0b%0b b=%0b%0b%0b%0b required 1%0b%0b%0b",
                             c, k, busy_a, done_a, read_a, addr_a, busy_b, done_b, read_b, addr_b,
                             k == lat, e_rd, e_ad);
                end
            end
            // Results at done, plus a start during done that must be ignored.
            for (int p = 0; p < 2; p++) begin
                tests++;
                if (id_ok_a !== e_idok || ts_ok_a !== 1'b1 || err_a !== 1'b0 || rc_a !== 4'd0 ||
                    idv_a !== idw || tsv_a !== tsw ||
                    id_ok_b !== e_idok || ts_ok_b !== e_tsb || err_b !== 1'b0 || rc_b !== 4'd0 ||
                    idv_b !== idw || tsv_b !== tsw) begin
                    fails++;
                    $display("FAIL seq_result c=%0d p=%0d: a ok=%0b%0b err=%0b rc=%0d id=%h ts=%h b ok=%0b%0b err=%0b rc=%0d required ok=%0b1/%0b%0b id=%h ts=%h",
                             c, p, id_ok_a, ts_ok_a, err_a, rc_a, idv_a, tsv_a,
                             id_ok_b, ts_ok_b, err_b, rc_b, e_idok, e_idok, e_tsb, idw, tsw);
                end
                if (p == 0) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                    @(negedge clk);
                    tests++;
                    if (busy_a !== 1'b0 || busy_b !== 1'b0 || read_a !== 1'b0 || done_a !== 1'b0) begin
                        fails++;
                        $display("FAIL start_at_done_ignored c=%0d: busy=%0b/%0b read=%0b done=%0b required 0",
                                 c, busy_a, busy_b, read_a, done_a);
                    end
                end
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        start = 1'b0;
        stuck = 1'b0;
        stall_target = 0;
        id_word = 32'h0;
        ts_word = 32'h0;
        rst_n = 1'b0;
        test_reset();
        test_reset_mid_sequence();
        test_timeout_retry();
        test_main_sequence();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sonic_v1_15_sysid_checker.md
# sonic_v1_15_sysid_checker

Boot-time sequencer that reads the NIOS base system-ID slave over a small Avalon-MM read master and checks it against build-time constants. Reads word 0 (system ID) and word 1 (timestamp), compares them, and reports match, mismatch or bus timeout to the firmware status logic. It sits between the reset/boot controller (which pulses `start`) and the sysid control slave in the NIOS base subsystem.

## Interface
Parameters:
- `EXPECTED_ID`, 953745243 (0x38D8FF5B), value required at word 0
- `EXPECTED_TS`, 0, value required at word 1
- `CHECK_TS`, 0, 1 = timestamp compare enabled; 0 = `ts_ok` forced 1
- `TIMEOUT_CYCLES`, 255, max consecutive waitrequest-high cycles per read (1..65535)
- `MAX_RETRIES`, 3, re-issues of a timed-out read before failing (0..15)

Ports:
- `clock`  in  1  single system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  pulse; begins a check sequence when idle
- `busy`  out  1  high from accepted start until done
- `done`  out  1  one-cycle pulse at end of sequence
- `id_ok`  out  1  word 0 equalled EXPECTED_ID (valid from done)
- `ts_ok`  out  1  word 1 equalled EXPECTED_TS or CHECK_TS=0
- `error`  out  1  a read exhausted retries (timeout)
- `id_value`  out  32  captured word 0
- `ts_value`  out  32  captured word 1
- `retry_count`  out  4  total retries used in last sequence (saturating)
- `avm_address`  out  1  word select: 0 = ID, 1 = timestamp
- `avm_read`  out  1  read request
- `avm_waitrequest`  in  1  slave stall
- `avm_readdata`  in  32  read data, valid on cycle where read && !waitrequest

## Operation
- States: IDLE, RD_ID, RD_TS, GAP, CHECK, DONE.
- IDLE: `start`=1 -> clear id_ok/ts_ok/error/retry_count, capture registers kept; go RD_ID. `start` ignored in all other states.
- RD_ID: avm_read=1, avm_address=0. Transfer completes on cycle with !waitrequest: capture readdata into id_value, clear timeout counter, go RD_TS.
- RD_TS: same with avm_address=1; on completion capture ts_value, go CHECK.
- Timeout: counter increments each cycle read && waitrequest. Reaching TIMEOUT_CYCLES -> if retries used for this read < MAX_RETRIES: go GAP (read low one cycle), increment retry_count, return to same read state with counter cleared; else set error=1, go DONE.
- GAP remembers which read (ID or TS) to resume.
- CHECK: id_ok <= (id_value == EXPECTED_ID); ts_ok <= CHECK_TS ? (ts_value == EXPECTED_TS) : 1; go DONE.
- DONE: done=1 for one cycle, go IDLE. On error path id_ok/ts_ok stay 0.
- Address and read held stable while waitrequest high (Avalon rule).
- retry_count saturates at 15; per-read retry budget is separate from it and resets on each completed read.

## Timing
- Reset values: busy=0, done=0, id_ok=0, ts_ok=0, error=0, id_value=0, ts_value=0, retry_count=0, avm_read=0, avm_address=0; state IDLE.
- All outputs registered; no combinational path input->output.
- Zero-wait slave: start sampled edge N; RD_ID cycle N+1, RD_TS N+2, CHECK N+3, done high N+4, busy high N+1..N+4, IDLE N+5.
- Each waitrequest cycle adds one cycle; each retry adds TIMEOUT_CYCLES+1 cycles.
- Result outputs stable from done until next accepted start.
- reset_n low mid-sequence: immediate return to reset values, avm_read drops asynchronously; no done pulse.
- start coincident with done: ignored (not IDLE).

## Test plan
- Zero-wait slave returning 953745243 / 0, CHECK_TS=0, start pulse -> done at start+4, id_ok=1, ts_ok=1, error=0, id_value=0x38D8FF5B, retry_count=0.
- Word 0 returns 0x12345678 -> done, id_ok=0, id_value=0x12345678, error=0.
- CHECK_TS=1, EXPECTED_TS=0x4C8A1F00, word 1 returns 0x4C8A1F01 -> id_ok=1, ts_ok=0.
- waitrequest high 3 cycles on each read -> done at start+10, results correct, retry_count=0, address/read stable during stalls.
- TIMEOUT_CYCLES=4, MAX_RETRIES=2, waitrequest stuck high -> avm_read low for one cycle after each 4 stalled cycles, two retries, then error=1, retry_count=2, done pulse, id_ok=0.
- Assert reset_n low during RD_TS stall -> all outputs to reset values same cycle; new start after release runs full clean sequence.
